// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity modes, FSM encoding, frame sizing.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_TURN   = 3'd5
  } tx_state_t;

  // Bit periods in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_cfg_if.sv
// Host push handshake into the UART transmitter FIFO.
interface uart_tx_fifo_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;

  modport master (output i_Tx_DV, output i_Tx_Byte, input o_Tx_Ready);
  modport slave  (input i_Tx_DV, input i_Tx_Byte, output o_Tx_Ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and registered full/empty flags.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  // Flags come from the registered count, so a full FIFO refuses a push even when popped.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with input FIFO, configurable framing and RS-485 driver-enable hold.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT    = 96,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned PARITY          = 0,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned TURNAROUND_CLKS = 0
) (
  input  logic                i_Clock,
  input  logic                i_Rst_L,
  uart_tx_fifo_cfg_if.slave   tx_if,
  output logic                o_Tx_Serial,
  output logic                o_Tx_DE,
  output logic                o_Tx_Active,
  output logic                o_Tx_Done,
  output logic                o_Fifo_Empty
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = $clog2(DATA_BITS);
  localparam int unsigned TURN_W = (TURNAROUND_CLKS > 1) ? $clog2(TURNAROUND_CLKS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [TURN_W-1:0] TURN_LAST =
    TURN_W'((TURNAROUND_CLKS > 0) ? TURNAROUND_CLKS - 1 : 0);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo_cfg: CLKS_PER_BIT must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
    $error("uart_tx_fifo_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_fifo_cfg: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_tx_fifo_cfg: STOP_BITS must be 1 or 2");
  end
  if (frame_bits(DATA_BITS, PARITY, STOP_BITS) > 13) begin : g_bad_frame
    $error("uart_tx_fifo_cfg: frame longer than 13 bit periods");
  end

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic [TURN_W-1:0]    turn_cnt;

  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 last_stop;
  logic                 pop;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .wr_en   (tx_if.i_Tx_DV),
    .wr_data (tx_if.i_Tx_Byte),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_if.o_Tx_Ready = !fifo_full;
  assign o_Fifo_Empty     = fifo_empty;

  // Pop whenever the line can take a new start bit: idle, turnaround, or end of last stop.
  assign bit_end   = (clk_cnt == CNT_LAST);
  assign last_stop = (stop_cnt == STOP_LAST);
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || (state == ST_TURN) ||
                ((state == ST_STOP) && bit_end && last_stop));

  // Frame sequencer; a pop at the end overrides the state's own next step.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state       <= ST_IDLE;
      shift       <= '0;
      parity_bit  <= 1'b0;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      stop_cnt    <= 1'b0;
      turn_cnt    <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_DE     <= 1'b0;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;

      if ((state == ST_START) || (state == ST_DATA) ||
          (state == ST_PARITY) || (state == ST_STOP)) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_DE     <= 1'b0;
        end
        ST_START: begin
          if (bit_end) begin
            state       <= ST_DATA;
            o_Tx_Serial <= shift[0];
            shift       <= {1'b0, shift[DATA_BITS-1:1]};
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_LAST) begin
              stop_cnt <= 1'b0;
              if (PARITY != PARITY_NONE) begin
                state       <= ST_PARITY;
                o_Tx_Serial <= parity_bit;
              end else begin
                state       <= ST_STOP;
                o_Tx_Serial <= 1'b1;
              end
            end else begin
              bit_idx     <= bit_idx + IDX_W'(1);
              o_Tx_Serial <= shift[0];
              shift       <= {1'b0, shift[DATA_BITS-1:1]};
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state       <= ST_STOP;
            stop_cnt    <= 1'b0;
            o_Tx_Serial <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              o_Tx_Done   <= 1'b1;
              o_Tx_Active <= 1'b0;
              o_Tx_Serial <= 1'b1;
              turn_cnt    <= '0;
              if (TURNAROUND_CLKS > 0) begin
                state <= ST_TURN;
              end else begin
                state   <= ST_IDLE;
                o_Tx_DE <= 1'b0;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        ST_TURN: begin
          o_Tx_Serial <= 1'b1;
          if (turn_cnt == TURN_LAST) begin
            state   <= ST_IDLE;
            o_Tx_DE <= 1'b0;
          end else begin
            turn_cnt <= turn_cnt + TURN_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Capture the next word and begin its start bit with the driver kept enabled.
      if (pop) begin
        state       <= ST_START;
        shift       <= fifo_rd_data;
        parity_bit  <= (^fifo_rd_data) ^ (PARITY == PARITY_ODD);
        clk_cnt     <= '0;
        bit_idx     <= '0;
        stop_cnt    <= 1'b0;
        o_Tx_Serial <= 1'b0;
        o_Tx_DE     <= 1'b1;
        o_Tx_Active <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench for uart_tx_fifo_cfg across several framing configurations.
module tb_uart_tx_fifo_cfg;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_fifo_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_tx_fifo_cfg_if #(.DATA_BITS(8)) if_e ();
  uart_tx_fifo_cfg_if #(.DATA_BITS(8)) if_o ();
  uart_tx_fifo_cfg_if #(.DATA_BITS(8)) if_t ();
  uart_tx_fifo_cfg_if #(.DATA_BITS(7)) if_s ();

  logic ser_a, de_a, act_a, done_a, emp_a;
  logic ser_e, de_e, act_e, done_e, emp_e;
  logic ser_o, de_o, act_o, done_o, emp_o;
  logic ser_t, de_t, act_t, done_t, emp_t;
  logic ser_s, de_s, act_s, done_s, emp_s;

  // 8N1, no turnaround
  uart_tx_fifo_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                     .FIFO_DEPTH(4), .TURNAROUND_CLKS(0)) u_a (
    .i_Clock(clk), .i_Rst_L(rst_n), .tx_if(if_a), .o_Tx_Serial(ser_a), .o_Tx_DE(de_a),
    .o_Tx_Active(act_a), .o_Tx_Done(done_a), .o_Fifo_Empty(emp_a));
  // 8E1
  uart_tx_fifo_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                     .FIFO_DEPTH(4), .TURNAROUND_CLKS(0)) u_e (
    .i_Clock(clk), .i_Rst_L(rst_n), .tx_if(if_e), .o_Tx_Serial(ser_e), .o_Tx_DE(de_e),
    .o_Tx_Active(act_e), .o_Tx_Done(done_e), .o_Fifo_Empty(emp_e));
  // 8O1
  uart_tx_fifo_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                     .FIFO_DEPTH(4), .TURNAROUND_CLKS(0)) u_o (
    .i_Clock(clk), .i_Rst_L(rst_n), .tx_if(if_o), .o_Tx_Serial(ser_o), .o_Tx_DE(de_o),
    .o_Tx_Active(act_o), .o_Tx_Done(done_o), .o_Fifo_Empty(emp_o));
  // 8N1 with 8-clock driver hold
  uart_tx_fifo_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                     .FIFO_DEPTH(4), .TURNAROUND_CLKS(8)) u_t (
    .i_Clock(clk), .i_Rst_L(rst_n), .tx_if(if_t), .o_Tx_Serial(ser_t), .o_Tx_DE(de_t),
    .o_Tx_Active(act_t), .o_Tx_Done(done_t), .o_Fifo_Empty(emp_t));
  // 7N2
  uart_tx_fifo_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2),
                     .FIFO_DEPTH(4), .TURNAROUND_CLKS(0)) u_s (
    .i_Clock(clk), .i_Rst_L(rst_n), .tx_if(if_s), .o_Tx_Serial(ser_s), .o_Tx_DE(de_s),
    .o_Tx_Active(act_s), .o_Tx_Done(done_s), .o_Fifo_Empty(emp_s));

  logic [4:0] ser, de, act, done;
  assign ser  = {ser_s, ser_t, ser_o, ser_e, ser_a};
  assign de   = {de_s, de_t, de_o, de_e, de_a};
  assign act  = {act_s, act_t, act_o, act_e, act_a};
  assign done = {done_s, done_t, done_o, done_e, done_a};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int idx, input logic dv, input logic [8:0] data);
    case (idx)
      0: begin if_a.i_Tx_DV = dv; if_a.i_Tx_Byte = data[7:0]; end
      1: begin if_e.i_Tx_DV = dv; if_e.i_Tx_Byte = data[7:0]; end
      2: begin if_o.i_Tx_DV = dv; if_o.i_Tx_Byte = data[7:0]; end
      3: begin if_t.i_Tx_DV = dv; if_t.i_Tx_Byte = data[7:0]; end
      default: begin if_s.i_Tx_DV = dv; if_s.i_Tx_Byte = data[6:0]; end
    endcase
  endtask

  // Called at a negedge; the word is sampled on the following posedge.
  task automatic push(input int idx, input logic [8:0] data);
    drive(idx, 1'b1, data);
    @(negedge clk);
    drive(idx, 1'b0, 9'h0);
  endtask

  // Waits (bounded) for a start bit, then records nbits bit periods; returns at the
  // negedge just after the frame, i.e. the cycle in which o_Tx_Done should be high.
  task automatic rx_frame(input int idx, input int nbits, output logic [15:0] bits,
                          output int bad, output logic to);
    int t = 0;
    bits = '0;
    bad  = 0;
    to   = 1'b0;
    while (ser[idx] !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      to = 1'b1;
      return;
    end
    for (int c = 0; c < nbits * int'(CPB); c++) begin
      if (c % int'(CPB) == 0) bits[c / int'(CPB)] = ser[idx];
      else if (ser[idx] !== bits[c / int'(CPB)]) bad++;
      if (de[idx] !== 1'b1) bad++;
      if (act[idx] !== 1'b1) bad++;
      if (c > 0 && done[idx] !== 1'b0) bad++;
      @(negedge clk);
    end
  endtask

  task automatic send(input int idx, input logic [8:0] data, input int nbits,
                      input logic [15:0] exp, input string tag);
    logic [15:0] bits;
    int          bad;
    logic        to;
    push(idx, data);
    rx_frame(idx, nbits, bits, bad, to);
    check({tag, "_timeout"}, 32'(to), 32'd0);
    check({tag, "_bits"}, 32'(bits), 32'(exp));
    check({tag, "_glitch"}, 32'(bad), 32'd0);
    check({tag, "_done"}, 32'(done[idx]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int          bad;
    logic        to;
    logic [6:0]  rdy_seen;
    int          cnt;

    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) drive(i, 1'b0, 9'h0);
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_serial", 32'(ser_a), 32'd1);
    check("rst_de", 32'(de_a), 32'd0);
    check("rst_active", 32'(act_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ready", 32'(if_a.o_Tx_Ready), 32'd1);
    check("rst_empty", 32'(emp_a), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 8N1 0xA5, start latency, frame bits and length, DE release
    push(0, 9'h0A5);
    check("t1_idle_line", 32'(ser_a), 32'd1);
    check("t1_fifo_loaded", 32'(emp_a), 32'd0);
    @(negedge clk);
    check("t1_start_latency", 32'(ser_a), 32'd0);
    check("t1_de_at_start", 32'(de_a), 32'd1);
    check("t1_popped", 32'(emp_a), 32'd1);
    rx_frame(0, 10, bits, bad, to);
    check("t1_timeout", 32'(to), 32'd0);
    check("t1_bits", 32'(bits), 32'h34A);
    check("t1_glitch", 32'(bad), 32'd0);
    check("t1_done_at_40", 32'(done_a), 32'd1);
    check("t1_de_off", 32'(de_a), 32'd0);
    check("t1_active_off", 32'(act_a), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done_a), 32'd0);

    // 2: parity even then odd on 0x07, 44-clock frame
    send(1, 9'h007, 11, 16'h60E, "t2_even");
    check("t2_even_de_off", 32'(de_e), 32'd0);
    send(2, 9'h007, 11, 16'h40E, "t2_odd");
    check("t2_odd_de_off", 32'(de_o), 32'd0);
    @(negedge clk);

    // 3: hold push 7 clocks into depth-4 FIFO; words 1..5 go out back-to-back
    fork
      begin
        for (int k = 1; k <= 7; k++) begin
          rdy_seen[k-1] = if_a.o_Tx_Ready;
          drive(0, 1'b1, 9'(k));
          @(negedge clk);
        end
        drive(0, 1'b0, 9'h0);
      end
      begin
        logic [15:0] fb;
        int          fbad;
        logic        fto;
        for (int w = 0; w < 5; w++) begin
          rx_frame(0, 10, fb, fbad, fto);
          check("t3_timeout", 32'(fto), 32'd0);
          check("t3_bits", 32'(fb), 32'h200 | (32'(w + 1) << 1));
          check("t3_glitch", 32'(fbad), 32'd0);
          check("t3_done", 32'(done_a), 32'd1);
          if (w < 4) check("t3_no_gap", 32'(ser_a), 32'd0);
          else       check("t3_de_off", 32'(de_a), 32'd0);
        end
        cnt = 0;
        repeat (60) begin
          @(negedge clk);
          if (ser_a !== 1'b1) cnt++;
        end
        check("t3_no_dropped_words", 32'(cnt), 32'd0);
      end
    join
    check("t3_ready_pattern", 32'(rdy_seen), 32'h1F);

    // 4a: single word with 8-clock driver hold
    send(3, 9'h03C, 10, 16'h278, "t4a");
    check("t4a_active_off", 32'(act_t), 32'd0);
    cnt = 0;
    while (de_t === 1'b1 && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    check("t4a_de_hold", 32'(cnt), 32'd8);
    repeat (2) @(negedge clk);

    // 4b: push during turnaround clock 3; DE never drops
    push(3, 9'h081);
    rx_frame(3, 10, bits, bad, to);
    check("t4b_first_bits", 32'(bits), 32'h302);
    check("t4b_first_done", 32'(done_t), 32'd1);
    cnt = 0;
    if (de_t !== 1'b1) cnt++;
    @(negedge clk);
    if (de_t !== 1'b1) cnt++;
    @(negedge clk);
    if (de_t !== 1'b1) cnt++;
    push(3, 9'h0C3);
    if (de_t !== 1'b1) cnt++;
    check("t4b_de_held", 32'(cnt), 32'd0);
    rx_frame(3, 10, bits, bad, to);
    check("t4b_timeout", 32'(to), 32'd0);
    check("t4b_second_bits", 32'(bits), 32'h386);
    check("t4b_second_glitch", 32'(bad), 32'd0);
    cnt = 0;
    while (de_t === 1'b1 && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
    check("t4b_de_hold", 32'(cnt), 32'd8);

    // 5: reset mid data bit 4 with two words queued
    push(0, 9'h00E);
    push(0, 9'h022);
    push(0, 9'h033);
    repeat (21) @(negedge clk);
    check("t5_pre_bit4", 32'(ser_a), 32'd0);
    check("t5_pre_queued", 32'(emp_a), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_serial", 32'(ser_a), 32'd1);
    check("t5_de", 32'(de_a), 32'd0);
    check("t5_active", 32'(act_a), 32'd0);
    check("t5_ready", 32'(if_a.o_Tx_Ready), 32'd1);
    check("t5_empty", 32'(emp_a), 32'd1);
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (ser_a !== 1'b1 || de_a !== 1'b0) cnt++;
    end
    check("t5_queue_discarded", 32'(cnt), 32'd0);

    // 6: 7N2 0x55, 40-clock frame
    send(4, 9'h055, 10, 16'h3AA, "t6");
    check("t6_de_off", 32'(de_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Parametrised UART transmitter for the JVS/analogizer serial path. It has configurable data width, parity, stop bits and an input FIFO. It also provides an RS-485 driver-enable output with a programmable turnaround hold. Host logic pushes words through a valid/ready handshake, and the block serialises them back-to-back, LSB first, with no idle gap while the FIFO has data.

Parameters:
CLKS_PER_BIT, 96, clocks per bit period (48 MHz / 500 kbaud); must be >= 2.
DATA_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits, 1 or 2.
FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2.
TURNAROUND_CLKS, 0, clocks o_Tx_DE is held high after the last stop bit when the FIFO is empty.

Ports:
i_Clock  in  1  system clock
i_Rst_L  in  1  synchronous active-low reset
i_Tx_DV  in  1  push strobe
i_Tx_Byte  in  DATA_BITS  word to send
o_Tx_Ready  out  1  FIFO not full
o_Tx_Serial  out  1  serial line, idle high
o_Tx_DE  out  1  RS-485 driver enable
o_Tx_Active  out  1  a frame is on the line
o_Tx_Done  out  1  one-clock pulse per completed frame
o_Fifo_Empty  out  1  FIFO holds no words

Behaviour:
- Clock and reset: the block runs on one clock, i_Clock. Reset is synchronous and active-low on i_Rst_L. All outputs are registered.
- Reset values: o_Tx_Serial = 1, o_Tx_DE = 0, o_Tx_Active = 0, o_Tx_Done = 0, o_Tx_Ready = 1, o_Fifo_Empty = 1. The state machine goes to IDLE, all counters clear, and the FIFO is flushed.
- Reset mid-frame: the line returns to 1 and o_Tx_DE goes to 0 on the very next edge. The partially sent word and all queued words are discarded.
- Push handshake: a push occurs when i_Tx_DV = 1 and o_Tx_Ready = 1. A push while o_Tx_Ready = 0 is silently dropped and has no side effects.
  - o_Tx_Ready is derived from the registered count, so a push into a full FIFO is dropped even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- State machine states: IDLE, START, DATA, PARITY, STOP, TURN.
- IDLE:
  - o_Tx_Serial = 1.
  - If the FIFO is non-empty: pop into the shift register. On the next cycle the state is START, o_Tx_Serial = 0, o_Tx_DE = 1 and o_Tx_Active = 1.
  - Latency from an accepted push into an idle, empty FIFO to the start bit on the line is 2 clocks.
- Bit timing: every bit lasts exactly CLKS_PER_BIT clocks. The bit counter width is clog2(CLKS_PER_BIT).
- DATA: DATA_BITS bits, LSB first.
- PARITY (state skipped when PARITY = 0):
  - Even parity bit = XOR of the data bits.
  - Odd parity bit = the inverse of that.
- STOP: STOP_BITS periods at 1.
- Frame length: CLKS_PER_BIT × (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) clocks.
- End of the last stop period:
  - o_Tx_Done pulses high for the next cycle.
  - If the FIFO is non-empty, pop and enter START directly, with zero idle clocks; o_Tx_DE and o_Tx_Active stay high.
  - Otherwise: o_Tx_Active = 0 and the state is TURN, or IDLE when TURNAROUND_CLKS = 0.
- TURN:
  - o_Tx_Serial = 1 and o_Tx_DE = 1 for TURNAROUND_CLKS clocks, then IDLE with o_Tx_DE = 0.
  - If a word becomes available during TURN, the hold is aborted: pop, and enter START on the next cycle with o_Tx_DE kept high.
- The word in flight is captured at pop time; later pushes never corrupt it.
- An illegal parameter value triggers a compile-time assertion (simulation-only initial check).

Decomposition:
- Package uart_pkg holds:
  - localparams PARITY_NONE, PARITY_ODD, PARITY_EVEN;
  - the state encoding (3-bit) for IDLE, START, DATA, PARITY, STOP, TURN;
  - a function frame_bits(DATA_BITS, PARITY, STOP_BITS).
- One sub-module, uart_sync_fifo (parameters WIDTH and DEPTH): synchronous active-low reset, registered count, and full/empty flags derived from the count. The top level holds the state machine, the shift register and the bit and turnaround counters.

Test Plan:
1. CLKS_PER_BIT=4, 8N1; push 0xA5. Required: line sequence 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 clocks. o_Tx_Done pulses exactly 40 clocks after the start-bit edge; o_Tx_DE goes high with the start bit and low right after the stop bit (TURNAROUND_CLKS=0).
2. PARITY=2; push 0x07. Required: parity bit = 1. With PARITY=1, same word: parity bit = 0. Frame length = 44 clocks.
3. FIFO_DEPTH=4; hold i_Tx_DV for 7 consecutive clocks with words 0x01..0x07. Required: o_Tx_Ready drops once 4 words are held, and later pushes are dropped. Accepted words leave back-to-back with no idle clock, o_Tx_DE stays high continuously, and there is one o_Tx_Done per frame.
4. TURNAROUND_CLKS=8; send a single 0x3C. Required: o_Tx_DE stays high for 8 clocks after the stop bit, then drops. Repeat with a push at clock 3 of TURN: the start bit begins without o_Tx_DE ever dropping.
5. Deassert i_Rst_L for one clock mid data bit 4, with 2 words queued. Required: next cycle o_Tx_Serial = 1, o_Tx_DE = 0, o_Tx_Active = 0, o_Tx_Ready = 1, o_Fifo_Empty = 1, and the queued words are never sent.
6. DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4; push 0x55. Required: 7 data bits, 1,0,1,0,1,0,1, followed by 8 clocks of stop. Frame length = 40 clocks.
